// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM for the 8-bit accumulator CPU.
// Optional memory timeout: define CPU_CTRL_MEM_TIMEOUT_EN.
module cpu_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ir_opcode,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mar_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mdr_load,
  output logic       acc_load,
  output logic       acc_src,
  output logic [2:0] alu_op,
  output logic       out_load,
  output logic       halted,
  output logic       fault
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_MEM    = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_OUT = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  logic [2:0] state_q, state_d;

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
`endif

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mar_sel  = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mdr_load = 1'b0;
    acc_load = 1'b0;
    acc_src  = 1'b0;
    alu_op   = 3'd0;
    out_load = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (ir_opcode)
          OP_JMP: pc_load = 1'b1;
          OP_JZ:  pc_load = flag_z;
          OP_JC:  pc_load = flag_c;
          OP_OUT: out_load = 1'b1;
          OP_HLT: state_d = S_HALT;
          OP_LDA, OP_STA, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_XOR: state_d = S_MEM;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mar_sel = 1'b1;
        mem_we  = (ir_opcode == OP_STA);
        if (mem_ack) begin
          if (ir_opcode == OP_STA) begin
            state_d = S_FETCH;
          end else if (ir_opcode == OP_LDA) begin
            mdr_load = 1'b1;
            acc_load = 1'b1;
            acc_src  = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_load = 1'b1;
            state_d  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        acc_load = 1'b1;
        alu_op   = ir_opcode[2:0] - 3'd3;
        state_d  = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
    // an ack in the limit cycle wins over the timeout
    wait_d  = wait_q;
    fault_d = fault_q;
    if (mem_req && !mem_ack) begin
      if (wait_q == TO_LIM) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
    if (state_d != state_q) wait_d = 8'd0;
    fault = fault_q;
`endif

    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mar_sel  = 1'b0;
      ir_load  = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      mdr_load = 1'b0;
      acc_load = 1'b0;
      acc_src  = 1'b0;
      alu_op   = 3'd0;
      out_load = 1'b0;
      halted   = 1'b0;
      fault    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm with a small datapath and memory model.
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ir_opcode;
  logic       flag_z;
  logic       flag_c = 1'b0;
  logic       mem_ack;
  logic       mem_req, mem_we, mar_sel, ir_load, pc_inc, pc_load;
  logic       mdr_load, acc_load, acc_src, out_load, halted, fault;
  logic [2:0] alu_op;

  cpu_ctrl_fsm #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ir_opcode(ir_opcode),
    .flag_z(flag_z), .flag_c(flag_c), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mar_sel(mar_sel),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .mdr_load(mdr_load), .acc_load(acc_load), .acc_src(acc_src),
    .alu_op(alu_op), .out_load(out_load), .halted(halted),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [11:0] s;
    logic [3:0]  a;
  } ev_t;

  localparam logic [11:0] EV_F   = 12'h300;
  localparam logic [11:0] EV_LDA = 12'h470;
  localparam logic [11:0] EV_MDR = 12'h440;
  localparam logic [11:0] EV_PCL = 12'h080;
  localparam logic [11:0] EV_OUT = 12'h008;
  localparam logic [11:0] EV_STA = 12'hC00;

  ev_t        exq[$];
  ev_t        e;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         dly_f = 0;
  int         dly_m = 0;
  int         wcnt = 0;
  logic [7:0] mem[16];
  logic [3:0] pc;
  logic [7:0] ir, mdr, acc, z;
  logic [3:0] addr;
  logic       prev_wait = 1'b0;
  logic [2:0] prev_m = 3'd0;

  assign ir_opcode = ir[7:4];
  assign flag_z    = (acc == 8'h00);
  assign addr      = mar_sel ? ir[3:0] : pc;
  assign mem_ack   = mem_req && (wcnt >= (mar_sel ? dly_m : dly_f));

  function automatic logic [11:0] ex(input logic [2:0] op);
    return 12'h020 | {9'd0, op};
  endfunction

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= rst ? 1 : cyc + 1;

  always @(posedge clk)
    wcnt <= (rst || !mem_req || mem_ack) ? 0 : wcnt + 1;

  always @(posedge clk) begin
    if (rst) begin
      pc <= 4'h0; ir <= 8'h00; mdr <= 8'h00; acc <= 8'h00; z <= 8'h00;
    end else begin
      if (ir_load) ir <= mem[addr];
      if (pc_inc) pc <= pc + 4'd1;
      else if (pc_load) pc <= ir[3:0];
      if (mdr_load) mdr <= mem[addr];
      if (acc_load) acc <= acc_src ? mem[addr] : alu(acc, mdr, alu_op);
      if (out_load) z <= acc;
      if (mem_req && mem_we && mem_ack) mem[addr] = acc;
    end
  end

  // monitor: every datapath action must match the next expected event
  always @(negedge clk) begin
    if (rst) begin
      prev_wait = 1'b0;
    end else begin
      if ((mem_req && mem_ack) || ir_load || pc_inc || pc_load ||
          mdr_load || acc_load || out_load) begin
        if (exq.size() == 0) begin
          chk("unexpected_event", cyc, 0);
        end else begin
          e = exq.pop_front();
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_strobes", {mem_we, mar_sel, ir_load, pc_inc, pc_load,
              mdr_load, acc_load, acc_src, out_load, alu_op}, e.s);
          chk("ev_addr", (mem_req && mem_ack) ? addr : 4'h0, e.a);
        end
      end
      if (prev_wait && mem_req)
        chk("wait_stable", {mem_req, mar_sel, mem_we}, prev_m);
      prev_wait = mem_req && !mem_ack;
      prev_m    = {mem_req, mar_sel, mem_we};
    end
  end

  task automatic push(input int c, input logic [11:0] s, input logic [3:0] a);
    ev_t n;
    n.cyc = c; n.s = s; n.a = a;
    exq.push_back(n);
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_outputs_zero", {mem_req, mem_we, mar_sel, ir_load, pc_inc,
        pc_load, mdr_load, acc_load, acc_src, alu_op, out_load, halted,
        fault}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("first_fetch", {mem_req, mar_sel}, 2'b10);
  endtask

  task automatic run_to_halt(input string nm, input int exp_cyc,
                             input logic exp_fault);
    int t;
    t = 0;
    while (!halted && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_halt_cyc"}, cyc, exp_cyc);
    repeat (2) @(negedge clk);
    chk({nm, "_queue_empty"}, exq.size(), 0);
    chk({nm, "_fault"}, fault, exp_fault);
    exq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_mem();
    mem[0] = 8'h1A; mem[1] = 8'h3B; mem[2] = 8'hB0; mem[3] = 8'hF0;
    mem[10] = 8'h05; mem[11] = 8'h07;
    push(1, EV_F, 4'h0); push(3, EV_LDA, 4'hA); push(4, EV_F, 4'h1);
    push(6, EV_MDR, 4'hB); push(7, ex(3'd0), 4'h0); push(8, EV_F, 4'h2);
    push(9, EV_OUT, 4'h0); push(10, EV_F, 4'h3);
    do_reset();
    run_to_halt("prog1", 12, 1'b0);
    chk("prog1_z", z, 8'h0C);

    clr_mem();
    mem[0] = 8'h3B; mem[1] = 8'hF0; mem[11] = 8'h07;
    dly_f = 3; dly_m = 3;
    push(4, EV_F, 4'h0); push(9, EV_MDR, 4'hB);
    push(10, ex(3'd0), 4'h0); push(14, EV_F, 4'h1);
    do_reset();
    run_to_halt("add_wait", 16, 1'b0);
    chk("add_wait_acc", acc, 8'h07);
    dly_f = 0; dly_m = 0;

    clr_mem();
    mem[0] = 8'h1A; mem[1] = 8'h7B; mem[2] = 8'hF0;
    mem[10] = 8'h05; mem[11] = 8'h07;
    push(1, EV_F, 4'h0); push(3, EV_LDA, 4'hA); push(4, EV_F, 4'h1);
    push(6, EV_MDR, 4'hB); push(7, ex(3'd4), 4'h0); push(8, EV_F, 4'h2);
    do_reset();
    run_to_halt("xor", 10, 1'b0);
    chk("xor_acc", acc, 8'h02);

    clr_mem();
    mem[0] = 8'h94; mem[4] = 8'hF0;
    push(1, EV_F, 4'h0); push(2, EV_PCL, 4'h0); push(3, EV_F, 4'h4);
    do_reset();
    run_to_halt("jz_taken", 5, 1'b0);

    clr_mem();
    mem[0] = 8'hA6; mem[6] = 8'hF0;
    flag_c = 1'b1;
    push(1, EV_F, 4'h0); push(2, EV_PCL, 4'h0); push(3, EV_F, 4'h6);
    do_reset();
    run_to_halt("jc_taken", 5, 1'b0);
    flag_c = 1'b0;

    clr_mem();
    mem[0] = 8'h1A; mem[1] = 8'h94; mem[2] = 8'hD0; mem[3] = 8'hF0;
    mem[4] = 8'hF0; mem[10] = 8'h05;
    push(1, EV_F, 4'h0); push(3, EV_LDA, 4'hA); push(4, EV_F, 4'h1);
    push(6, EV_F, 4'h2); push(8, EV_F, 4'h3);
    do_reset();
    run_to_halt("jz_fall", 10, 1'b0);

    clr_mem();
    mem[0] = 8'h2C; mem[1] = 8'hF0; mem[12] = 8'h55;
    dly_m = 255;
    push(1, EV_F, 4'h0);
    do_reset();
    while (cyc < 4) @(negedge clk);
    chk("sta_wait_strobes", {mem_req, mar_sel, mem_we}, 3'b111);
    chk("sta_wait_queue", exq.size(), 0);
    rst = 1'b1;
    dly_m = 0;
    push(1, EV_F, 4'h0); push(3, EV_STA, 4'hC); push(4, EV_F, 4'h1);
    do_reset();
    chk("sta_abandoned", mem[12], 8'h55);
    run_to_halt("sta", 6, 1'b0);
    chk("sta_written", mem[12], 8'h00);

    clr_mem();
    mem[0] = 8'h8E;
    push(1, EV_F, 4'h0); push(2, EV_PCL, 4'h0); push(3, EV_F, 4'hE);
    push(5, EV_F, 4'hF); push(7, EV_F, 4'h0);
    do_reset();
    while (cyc < 3) @(negedge clk);
    mem[0] = 8'hF0;
    run_to_halt("pc_wrap", 9, 1'b0);

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
    clr_mem();
    mem[0] = 8'hF0;
    dly_f = 255;
    do_reset();
    run_to_halt("timeout", 6, 1'b1);

    dly_f = 4;
    push(5, EV_F, 4'h0);
    do_reset();
    run_to_halt("late_ack", 7, 1'b0);
    dly_f = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
